shift_unit: RTL and testbench
=============================

# shift_unit

Iterative, parametrised shift execution unit for the RV32I core's execute stage. It decodes register and immediate shifts (SLL/SRL/SRA and their I-type forms) and masks the shift amount to log2(XLEN) bits. It then shifts the operand by up to STEP bits per cycle. Valid/ready handshakes connect it to issue and writeback, and it supports a pipeline flush.

## Interface
- XLEN, 32: datapath width; power of 2, 32 or 64.
- STEP, 4: maximum bits shifted per cycle; power of 2, 1..XLEN.
- SHW (localparam), $clog2(XLEN): shift-amount width.

- clk  in  1  rising-edge clock (single clock domain)
- rst  in  1  synchronous, active-high reset
- flush  in  1  abort the in-flight operation; synchronous
- in_valid  in  1  issue request
- in_ready  out  1  unit can accept a request
- op  in  7  opcode
- funct3  in  3  funct3 field
- funct7_b5  in  1  instr[30] for R-type shifts
- rs1  in  XLEN  operand to shift
- rs2  in  XLEN  R-type shift source; only [SHW-1:0] is used
- imm  in  XLEN  decoded I-type immediate
- out_valid  out  1  result available
- out_ready  in  1  writeback accepts the result
- result  out  XLEN  shifted value
- out_err  out  1  request was not a legal shift

## Operation
- Decode:
  - op=0010011 selects the immediate form: shamt=imm[SHW-1:0], and imm[11:SHW] must be all zero except bit 10.
  - op=0110011 selects the register form: shamt=rs2[SHW-1:0].
  - funct3=001 is SLL. It requires bit10 (I-type) or funct7_b5 (R-type) to be 0.
  - funct3=101 is SRL when bit10/funct7_b5=0 and SRA when it is 1.
  - Any other op/funct3 combination, or a nonzero reserved immediate bit, is illegal. This includes imm[5]=1 when XLEN=32.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch acc=rs1, type, rem=shamt, err; clear the cycle counter.
  - Go to DONE if err or N=0; otherwise go to SHIFT.
- SHIFT:
  - Each cycle, acc shifts by k=min(STEP,rem) and rem decrements by k.
  - SRA fills with the sign bit latched at accept; SLL/SRL fill with zeros.
  - Leave for DONE after N cycles (N is defined under Configuration).
- DONE:
  - out_valid=1; result=acc, or 0 when err; out_err=err.
  - result and out_err hold stable until out_ready. On out_valid&&out_ready, go to IDLE.
- in_ready is 0 in SHIFT and DONE. The unit handles one operation at a time, with no overlap of accept and completion.
- flush: any state goes to IDLE the next cycle, and out_valid drops. flush beats a same-cycle in_valid, which is not accepted, and beats out_ready.
- rst behaves like flush and also clears the datapath.

## Timing
- Reset values: state=IDLE, out_valid=0, out_err=0, result=0, acc=0. in_ready=0 while rst is high.
- Accept happens at edge 0. out_valid rises at edge N+1. Illegal requests and shamt=0 give out_valid at edge 1.
- Results are registered outputs; there is no combinational in->out path.
- in_ready is a function of state only, and never depends on in_valid.
- Back-to-back issue: the next accept is possible in the cycle after the out handshake.

## Configuration
- SHIFT_UNIT_EARLY_DONE_EN:
  - Defined: N=ceil(shamt/STEP), so latency varies from 1 to XLEN/STEP+1.
  - Undefined: N=XLEN/STEP for every legal op, giving fixed latency XLEN/STEP+1. Cycles after rem reaches 0 shift by 0.
  - Illegal ops take 1 cycle in both modes.

## Structure
- Package shift_pkg holds:
  - opcode constants OPC_OP_IMM and OPC_OP;
  - funct3 constants F3_SLL and F3_SRX;
  - enum shift_type_e {SH_SLL, SH_SRL, SH_SRA};
  - enum state_e {IDLE, SHIFT, DONE}.
- Sub-module shift_decode is purely combinational. It maps op, funct3, funct7_b5, imm and rs2 to type, shamt and err.
- shift_unit holds the FSM, counter and datapath.

## Test plan
All scenarios use XLEN=32, STEP=4.
- SLLI: rs1=0x00000001, imm=0x005 -> result 0x00000020. out_valid at edge 3 with EN, edge 9 without.
- SRA: op=0110011, funct7_b5=1, rs1=0x80000000, rs2=0xFFFFFFE4 (shamt 4) -> 0xF8000000, out_err=0.
- SRLI: rs1=0x80000000, imm=0x01F -> 0x00000001. SRAI with imm=0x41F -> 0xFFFFFFFF.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> result and out_valid stable, in_ready=0. Raise out_ready -> IDLE the next cycle.
- Flush in the 2nd SHIFT cycle, with in_valid high in the same cycle -> no out_valid, request not accepted, in_ready=1 the next cycle.
- Illegal input: SLLI imm=0x020, or funct3=010 -> out_err=1, result=0, out_valid at edge 1 in both configurations.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared constants and enumerations for the iterative RV32I/RV64I shift unit.
package shift_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

    typedef enum logic [1:0] {
        SH_SLL,
        SH_SRL,
        SH_SRA
    } shift_type_e;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

endpackage

// File: rtl/shift_decode.sv
// Combinational decode of register/immediate shifts into shift type, masked amount and legality.
module shift_decode
    import shift_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [6:0]              op,
    input  logic [2:0]              funct3,
    input  logic                    funct7_b5,
    input  logic [XLEN-1:0]         imm,
    input  logic [XLEN-1:0]         rs2,
    output shift_type_e             sh_type,
    output logic [$clog2(XLEN)-1:0] shamt,
    output logic                    err
);

    localparam int SHW = $clog2(XLEN);
    // Reserved immediate bits: everything from SHW up to bit 11, except bit 10 (the SRA selector).
    localparam logic [11:0] RSV_MASK = (12'hFFF << SHW) & ~12'h400;

    logic           w_form_ok;
    logic           w_rsv_ok;
    logic           w_bit10;
    logic [SHW-1:0] w_shamt;
    logic           w_unused;

    assign w_unused = ^{imm[XLEN-1:12], rs2[XLEN-1:SHW]};

    always_comb begin
        w_form_ok = 1'b0;
        w_rsv_ok  = 1'b1;
        w_bit10   = 1'b0;
        w_shamt   = '0;
        if (op == OPC_OP_IMM) begin
            w_form_ok = 1'b1;
            w_bit10   = imm[10];
            w_shamt   = imm[SHW-1:0];
            w_rsv_ok  = ((imm[11:0] & RSV_MASK) == 12'h000);
        end else if (op == OPC_OP) begin
            w_form_ok = 1'b1;
            w_bit10   = funct7_b5;
            w_shamt   = rs2[SHW-1:0];
        end
    end

    always_comb begin
        sh_type = SH_SLL;
        shamt   = '0;
        err     = 1'b1;
        if (w_form_ok && w_rsv_ok) begin
            if (funct3 == F3_SLL && !w_bit10) begin
                sh_type = SH_SLL;
                shamt   = w_shamt;
                err     = 1'b0;
            end else if (funct3 == F3_SRX) begin
                sh_type = w_bit10 ? SH_SRA : SH_SRL;
                shamt   = w_shamt;
                err     = 1'b0;
            end
        end
    end

endmodule

// File: rtl/shift_unit.sv
// Iterative shift execution unit: shifts up to STEP bits per cycle behind valid/ready handshakes.
// Optional SHIFT_UNIT_EARLY_DONE_EN: finish after ceil(shamt/STEP) cycles instead of XLEN/STEP.
module shift_unit
    import shift_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int STEP = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      op,
    input  logic [2:0]      funct3,
    input  logic            funct7_b5,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            out_err
);

    localparam int SHW = $clog2(XLEN);
    localparam int CW  = SHW + 1;
    localparam logic [CW-1:0] STEP_V = CW'(STEP);
    localparam logic [CW-1:0] NFIX   = CW'(XLEN / STEP);

    state_e          r_state;
    state_e          w_state_nxt;
    logic [XLEN-1:0] r_acc;
    logic [SHW-1:0]  r_rem;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   r_n;
    logic            r_sign;
    logic            r_err;
    shift_type_e     r_type;
    logic            r_out_valid;
    logic [XLEN-1:0] r_result;
    logic            r_out_err;

    shift_type_e     w_type;
    logic [SHW-1:0]  w_shamt;
    logic            w_err;
    logic [CW-1:0]   w_n;
    logic [CW-1:0]   w_k;
    logic [CW-1:0]   w_rem_ext;
    logic [XLEN-1:0] w_fill;
    logic [XLEN-1:0] w_shifted;
    logic            w_accept;
    logic            w_out_hs;
    logic            w_load_out;
    logic            w_last;

    shift_decode #(.XLEN(XLEN)) u_decode (
        .op        (op),
        .funct3    (funct3),
        .funct7_b5 (funct7_b5),
        .imm       (imm),
        .rs2       (rs2),
        .sh_type   (w_type),
        .shamt     (w_shamt),
        .err       (w_err)
    );

`ifdef SHIFT_UNIT_EARLY_DONE_EN
    localparam int SL = $clog2(STEP);
    assign w_n = ({1'b0, w_shamt} + (STEP_V - CW'(1))) >> SL;
`else
    assign w_n = NFIX;
`endif

    // Per-cycle step k = min(STEP, rem); SRA fills vacated high bits with the latched sign.
    always_comb begin
        w_rem_ext = {1'b0, r_rem};
        w_k       = (w_rem_ext < STEP_V) ? w_rem_ext : STEP_V;
        w_fill    = r_sign ? ~({XLEN{1'b1}} >> w_k) : '0;
        w_shifted = (r_type == SH_SLL) ? (r_acc << w_k) : ((r_acc >> w_k) | w_fill);
    end

    assign w_last = ((r_cnt + CW'(1)) == r_n);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = (w_err || w_n == '0) ? DONE : SHIFT;
            SHIFT:   if (w_last) w_state_nxt = DONE;
            DONE:    if (w_out_hs) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (flush) w_state_nxt = IDLE;
    end

    always_comb begin
        in_ready   = (r_state == IDLE) && !rst;
        w_accept   = in_valid && in_ready && !flush;
        w_out_hs   = r_out_valid && out_ready;
        w_load_out = (r_state == DONE) && !r_out_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc  <= '0;
            r_rem  <= '0;
            r_cnt  <= '0;
            r_n    <= '0;
            r_sign <= 1'b0;
            r_err  <= 1'b0;
            r_type <= SH_SLL;
        end else if (w_accept) begin
            r_acc  <= rs1;
            r_rem  <= w_shamt;
            r_cnt  <= '0;
            r_n    <= w_n;
            r_sign <= rs1[XLEN-1] && (w_type == SH_SRA);
            r_err  <= w_err;
            r_type <= w_type;
        end else if (r_state == SHIFT && !flush) begin
            r_acc <= w_shifted;
            r_rem <= r_rem - w_k[SHW-1:0];
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Output registers load one cycle after entering DONE and hold until the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_out_err   <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_load_out) begin
            r_out_valid <= 1'b1;
            r_result    <= r_err ? '0 : r_acc;
            r_out_err   <= r_err;
        end else if (w_out_hs) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign out_err   = r_out_err;

endmodule

// File: tb/tb_shift_unit.sv
// Directed table-driven bench for shift_unit (XLEN=32, STEP=4), both latency configurations.
module tb_shift_unit;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7_b5;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        out_err;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] res;
        logic        err;
        int          lat_en;
        int          lat_fix;
    } vec_t;

    vec_t vecs[13];

    shift_unit #(.XLEN(32), .STEP(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .funct3    (funct3),
        .funct7_b5 (funct7_b5),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input vec_t v);
`ifdef SHIFT_UNIT_EARLY_DONE_EN
        return v.lat_en;
`else
        return v.lat_fix;
`endif
    endfunction

    // Called at posedge+1: issue one request, wait for out_valid, compare, then handshake.
    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        op        = v.op;
        funct3    = v.f3;
        funct7_b5 = v.f7;
        rs1       = v.rs1;
        rs2       = v.rs2;
        imm       = v.imm;
        in_valid  = 1'b1;
        chk($sformatf("v%0d_in_ready_idle", idx), 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(exp_lat(v)));
        chk($sformatf("v%0d_result", idx), result, v.res);
        chk($sformatf("v%0d_out_err", idx), 32'(out_err), 32'(v.err));
        chk($sformatf("v%0d_in_ready_busy", idx), 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk($sformatf("v%0d_out_valid_drop", idx), 32'(out_valid), 32'd0);
    endtask

    initial begin
        int lat;
        int seen;
        logic [31:0] held;
        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = '0;
        funct3    = '0;
        funct7_b5 = 1'b0;
        rs1       = '0;
        rs2       = '0;
        imm       = '0;

        //         op           f3      f7    rs1           rs2           imm           result        err  en fix
        vecs[0]  = '{7'b0010011, 3'b001, 1'b0, 32'h00000001, 32'h00000000, 32'h00000005, 32'h00000020, 1'b0, 3, 9};
        vecs[1]  = '{7'b0110011, 3'b101, 1'b1, 32'h80000000, 32'hFFFFFFE4, 32'h00000000, 32'hF8000000, 1'b0, 2, 9};
        vecs[2]  = '{7'b0010011, 3'b101, 1'b0, 32'h80000000, 32'h00000000, 32'h0000001F, 32'h00000001, 1'b0, 9, 9};
        vecs[3]  = '{7'b0010011, 3'b101, 1'b0, 32'h80000000, 32'h00000000, 32'h0000041F, 32'hFFFFFFFF, 1'b0, 9, 9};
        vecs[4]  = '{7'b0010011, 3'b001, 1'b0, 32'h00000001, 32'h00000000, 32'h00000020, 32'h00000000, 1'b1, 1, 1};
        vecs[5]  = '{7'b0010011, 3'b010, 1'b0, 32'h00000001, 32'h00000000, 32'h00000003, 32'h00000000, 1'b1, 1, 1};
        vecs[6]  = '{7'b0110011, 3'b001, 1'b0, 32'h12345678, 32'h00000000, 32'h00000000, 32'h12345678, 1'b0, 1, 9};
        vecs[7]  = '{7'b0110011, 3'b101, 1'b0, 32'hF0F0F0F0, 32'h00000023, 32'h00000000, 32'h1E1E1E1E, 1'b0, 2, 9};
        vecs[8]  = '{7'b0110011, 3'b001, 1'b1, 32'h00000001, 32'h00000001, 32'h00000000, 32'h00000000, 1'b1, 1, 1};
        vecs[9]  = '{7'b0000011, 3'b001, 1'b0, 32'h00000001, 32'h00000001, 32'h00000001, 32'h00000000, 1'b1, 1, 1};
        vecs[10] = '{7'b0010011, 3'b101, 1'b0, 32'h40000000, 32'h00000000, 32'h00000402, 32'h10000000, 1'b0, 2, 9};
        vecs[11] = '{7'b0110011, 3'b001, 1'b0, 32'h0000000F, 32'h0000001D, 32'h00000000, 32'hE0000000, 1'b0, 9, 9};
        vecs[12] = '{7'b0010011, 3'b101, 1'b0, 32'h00000001, 32'h00000000, 32'h00000801, 32'h00000000, 1'b1, 1, 1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_result", result, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

        // Backpressure: hold out_ready low for 5 cycles after out_valid
        op = 7'b0010011; funct3 = 3'b001; funct7_b5 = 1'b0;
        rs1 = 32'h00000001; rs2 = '0; imm = 32'h00000005;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_latency", 32'(lat), 32'(exp_lat(vecs[0])));
        held = result;
        chk("bp_result", held, 32'h00000020);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_hold%0d_valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("bp_hold%0d_result", c), result, held);
            chk($sformatf("bp_hold%0d_in_ready", c), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);

        // Flush in the 2nd SHIFT cycle with a competing in_valid
        op = 7'b0010011; funct3 = 3'b101; funct7_b5 = 1'b0;
        rs1 = 32'h80000000; imm = 32'h0000001F;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        imm = 32'h00000001;
        in_valid = 1'b1;
        flush = 1'b1;
        chk("flush_in_ready_busy", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_in_ready_next", 32'(in_ready), 32'd1);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        chk("flush_no_late_valid", 32'(seen), 32'd0);
        chk("flush_idle_after", 32'(in_ready), 32'd1);

        // Recovery after flush
        run_vec(100, vecs[7]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
